// File: rtl/cnn_pkg.sv
// ============================================================================
// Module   : cnn_pkg
// Brief    : Shared pixel type and default geometry for the CNN layer blocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cnn_pkg;

    localparam int DW    = 16;
    localparam int CH    = 4;
    localparam int DEPTH = 16;

    typedef logic signed [DW-1:0] pixel_t;

endpackage : cnn_pkg

`default_nettype wire

// File: rtl/bridge_fifo_mem.sv
// ============================================================================
// Module   : bridge_fifo_mem
// Brief    : DEPTH x WIDTH storage, one synchronous write port, one async read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bridge_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset; the FIFO's count gates every read.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : bridge_fifo_mem

`default_nettype wire

// File: rtl/layer_bridge_fifo.sv
// ============================================================================
// Module   : layer_bridge_fifo
// Brief    : Multi-channel inter-layer FIFO with FWFT or registered read,
//            back-pressure flags, occupancy count and sticky error flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module layer_bridge_fifo
    import cnn_pkg::*;
#(
    parameter int DW       = cnn_pkg::DW,
    parameter int CH       = cnn_pkg::CH,
    parameter int DEPTH    = cnn_pkg::DEPTH,
    parameter int AF_LEVEL = 12,
    parameter bit FWFT     = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic signed [DW-1:0]      data_in  [0:CH-1],
    output logic                      full,
    output logic                      almost_full,
    input  logic                      rd_en,
    output logic signed [DW-1:0]      data_out [0:CH-1],
    output logic                      empty,
    output logic                      rd_valid,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clear_err
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CW    = c_AW + 1;
    localparam int c_WIDTH = CH * DW;

    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_af;
    logic               r_ovf;
    logic               r_unf;

    logic               w_wr_acc;
    logic               w_rd_acc;
    logic [c_CW-1:0]    w_count_nxt;
    logic [c_WIDTH-1:0] w_wr_data;
    logic [c_WIDTH-1:0] w_rd_data;
    logic signed [DW-1:0] w_rd_pix [0:CH-1];

    // Acceptance uses only registered flags, so a full FIFO never passes through.
    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + c_CW'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - c_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_af    <= (w_count_nxt >= c_CW'(AF_LEVEL));
            // A new error in the same cycle as clear_err keeps the flag set.
            if (wr_en && r_full) begin
                r_ovf <= 1'b1;
            end else if (clear_err) begin
                r_ovf <= 1'b0;
            end
            if (rd_en && r_empty) begin
                r_unf <= 1'b1;
            end else if (clear_err) begin
                r_unf <= 1'b0;
            end
        end
    end

    generate
        for (genvar ch = 0; ch < CH; ch++) begin : g_pack
            assign w_wr_data[ch*DW +: DW] = data_in[ch];
            assign w_rd_pix[ch]           = w_rd_data[ch*DW +: DW];
        end
    endgenerate

    bridge_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (c_WIDTH),
        .AW    (c_AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    generate
        if (FWFT) begin : g_fwft
            logic signed [DW-1:0] r_last [0:CH-1];

            // Remembers the head shown before the FIFO drained so data_out holds.
            always_ff @(posedge clk) begin
                for (int i = 0; i < CH; i++) begin
                    if (reset) begin
                        r_last[i] <= '0;
                    end else if (!r_empty) begin
                        r_last[i] <= w_rd_pix[i];
                    end
                end
            end

            for (genvar ch = 0; ch < CH; ch++) begin : g_out
                assign data_out[ch] = r_empty ? r_last[ch] : w_rd_pix[ch];
            end
            assign rd_valid = ~r_empty;
        end else begin : g_reg
            logic signed [DW-1:0] r_dout [0:CH-1];
            logic                 r_rd_valid;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                end
                for (int i = 0; i < CH; i++) begin
                    if (reset) begin
                        r_dout[i] <= '0;
                    end else if (w_rd_acc) begin
                        r_dout[i] <= w_rd_pix[i];
                    end
                end
            end

            for (genvar ch = 0; ch < CH; ch++) begin : g_out
                assign data_out[ch] = r_dout[ch];
            end
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign full        = r_full;
    assign almost_full = r_af;
    assign empty       = r_empty;
    assign count       = r_count;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;

endmodule : layer_bridge_fifo

`default_nettype wire

// File: tb/tb_layer_bridge_fifo.sv
// ============================================================================
// Module   : tb_layer_bridge_fifo
// Brief    : Directed bench for layer_bridge_fifo in FWFT and registered modes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_layer_bridge_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // FWFT instance
    logic               f_rst, f_wr, f_rd, f_clr;
    logic signed [15:0] f_din  [0:3];
    logic signed [15:0] f_dout [0:3];
    logic               f_full, f_af, f_empty, f_rv, f_ovf, f_unf;
    logic [4:0]         f_count;

    // Registered-read instance
    logic               r_rst, r_wr, r_rd, r_clr;
    logic signed [15:0] r_din  [0:3];
    logic signed [15:0] r_dout [0:3];
    logic               r_full, r_af, r_empty, r_rv, r_ovf, r_unf;
    logic [4:0]         r_count;

    layer_bridge_fifo #(.DW(16), .CH(4), .DEPTH(16), .AF_LEVEL(12), .FWFT(1'b1)) u_dut_fwft (
        .clk(clk), .reset(f_rst), .wr_en(f_wr), .data_in(f_din), .full(f_full),
        .almost_full(f_af), .rd_en(f_rd), .data_out(f_dout), .empty(f_empty),
        .rd_valid(f_rv), .count(f_count), .overflow(f_ovf), .underflow(f_unf),
        .clear_err(f_clr)
    );

    layer_bridge_fifo #(.DW(16), .CH(4), .DEPTH(16), .AF_LEVEL(12), .FWFT(1'b0)) u_dut_reg (
        .clk(clk), .reset(r_rst), .wr_en(r_wr), .data_in(r_din), .full(r_full),
        .almost_full(r_af), .rd_en(r_rd), .data_out(r_dout), .empty(r_empty),
        .rd_valid(r_rv), .count(r_count), .overflow(r_ovf), .underflow(r_unf),
        .clear_err(r_clr)
    );

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    typedef struct {
        logic        rst, wr, rd, clr;
        logic [63:0] din;
        logic [4:0]  cnt;
        logic        emp, ful, af, ovf, unf;
        logic [63:0] dout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, wr, rd, clr, input logic [63:0] din,
                                input logic [4:0] cnt, input logic emp, ful, af, ovf, unf,
                                input logic [63:0] dout);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
        v.cnt = cnt; v.emp = emp; v.ful = ful; v.af = af; v.ovf = ovf; v.unf = unf;
        v.dout = dout;
        return v;
    endfunction

    function automatic logic [74:0] f_status();
        return {f_count, f_empty, f_full, f_af, f_rv, f_ovf, f_unf,
                f_dout[3], f_dout[2], f_dout[1], f_dout[0]};
    endfunction

    task automatic f_drive(input logic rst, wr, rd, clr, input logic [63:0] din);
        f_rst = rst; f_wr = wr; f_rd = rd; f_clr = clr;
        for (int i = 0; i < 4; i++) f_din[i] = din[i*16 +: 16];
    endtask

    task automatic check(input string name, input logic [74:0] got, input logic [74:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model of the FWFT instance
    logic [63:0] q[$];
    logic [63:0] m_last;
    logic        m_ovf, m_unf;

    task automatic fop(input string name, input logic rst, wr, rd, clr, input logic [63:0] din);
        logic        wa, ra;
        logic [63:0] exp_d;
        int          sz;
        f_drive(rst, wr, rd, clr, din);
        @(posedge clk);
        #1;
        sz = q.size();
        if (rst) begin
            q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_last = '0;
        end else begin
            wa = wr && (sz != 16);
            ra = rd && (sz != 0);
            if (sz != 0) m_last = q[0];
            if (wr && sz == 16) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
            if (rd && sz == 0)  m_unf = 1'b1; else if (clr) m_unf = 1'b0;
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(din);
        end
        sz = q.size();
        exp_d = (sz != 0) ? q[0] : m_last;
        check(name, f_status(),
              {5'(sz), sz == 0, sz == 16, sz >= 12, sz != 0, m_ovf, m_unf, exp_d});
    endtask

    function automatic logic [70:0] r_status();
        return {r_count, r_empty, r_rv, r_unf, r_dout[3], r_dout[2], r_dout[1], r_dout[0]};
    endfunction

    task automatic rstep(input string name, input logic rst, wr, rd,
                         input logic [63:0] din, input logic [4:0] cnt,
                         input logic emp, rv, unf, input logic [63:0] dout);
        r_rst = rst; r_wr = wr; r_rd = rd; r_clr = 1'b0;
        for (int i = 0; i < 4; i++) r_din[i] = din[i*16 +: 16];
        @(posedge clk);
        #1;
        checks++;
        if (r_status() !== {cnt, emp, rv, unf, dout}) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, r_status(), {cnt, emp, rv, unf, dout});
        end
    endtask

    initial begin
        f_drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        r_rst = 1'b1; r_wr = 1'b0; r_rd = 1'b0; r_clr = 1'b0;
        for (int i = 0; i < 4; i++) r_din[i] = '0;
        q.delete(); m_last = '0; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset, idle, two writes, reads to empty, underflow, clear
        tbl.push_back(mk(1,0,0,0, '0,            0, 1,0,0,0,0, '0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,0,0, '0,        0, 1,0,0,0,0, '0));
        tbl.push_back(mk(0,1,0,0, pk(1,2,3,4),   1, 0,0,0,0,0, pk(1,2,3,4)));
        tbl.push_back(mk(0,1,0,0, pk(5,6,7,8),   2, 0,0,0,0,0, pk(1,2,3,4)));
        tbl.push_back(mk(0,0,1,0, '0,            1, 0,0,0,0,0, pk(5,6,7,8)));
        tbl.push_back(mk(0,0,1,0, '0,            0, 1,0,0,0,0, pk(5,6,7,8)));
        tbl.push_back(mk(0,0,1,0, '0,            0, 1,0,0,0,1, pk(5,6,7,8)));
        tbl.push_back(mk(0,0,0,1, '0,            0, 1,0,0,0,0, pk(5,6,7,8)));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            f_drive(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), f_status(),
                  {tbl[i].cnt, tbl[i].emp, tbl[i].ful, tbl[i].af, ~tbl[i].emp,
                   tbl[i].ovf, tbl[i].unf, tbl[i].dout});
        end

        // Fill to full, overflow, drain in order across the pointer wrap
        fop("rst3", 1, 0, 0, 0, '0);
        for (int k = 0; k < 16; k++)
            fop($sformatf("fill%0d", k), 0, 1, 0, 0, pk(k, k + 100, k + 200, k + 300));
        fop("wr17", 0, 1, 0, 0, pk(99, 99, 99, 99));
        for (int k = 0; k < 16; k++)
            fop($sformatf("drain%0d", k), 0, 0, 1, 0, '0);

        // Simultaneous read/write at count 5, then at full
        fop("clr4", 0, 0, 0, 1, '0);
        for (int k = 0; k < 5; k++)
            fop($sformatf("pre%0d", k), 0, 1, 0, 0, pk(500 + k, -k, k, 7));
        for (int k = 0; k < 10; k++)
            fop($sformatf("rw%0d", k), 0, 1, 1, 0, pk(600 + k, -k - 1, k * 3, -7));
        for (int k = 0; k < 11; k++)
            fop($sformatf("top%0d", k), 0, 1, 0, 0, pk(700 + k, k, -k, 1));
        fop("rwfull", 0, 1, 1, 0, pk(800, 1, 2, 3));

        // Reset mid-stream, then clear and overflow in the same cycle
        fop("rst6a", 1, 0, 0, 0, '0);
        for (int k = 0; k < 7; k++)
            fop($sformatf("mid%0d", k), 0, 1, 0, 0, pk(k, k, k, k));
        fop("rst6b", 1, 1, 0, 0, pk(42, 42, 42, 42));
        for (int k = 0; k < 16; k++)
            fop($sformatf("refill%0d", k), 0, 1, 0, 0, pk(900 + k, 0, 0, 0));
        fop("clrset", 0, 1, 0, 1, pk(1, 1, 1, 1));

        // Registered-read instance
        rstep("r_rst",  1, 0, 0, '0,                0, 1, 0, 0, '0);
        rstep("r_wr",   0, 1, 0, pk(-1,-2,-3,-4),   1, 0, 0, 0, '0);
        rstep("r_rd",   0, 0, 1, '0,                0, 1, 1, 0, pk(-1,-2,-3,-4));
        rstep("r_idle", 0, 0, 0, '0,                0, 1, 0, 0, pk(-1,-2,-3,-4));
        rstep("r_unf",  0, 0, 1, '0,                0, 1, 0, 1, pk(-1,-2,-3,-4));
        rstep("r_wa",   0, 1, 0, pk(10,11,12,13),   1, 0, 0, 1, pk(-1,-2,-3,-4));
        rstep("r_wb",   0, 1, 0, pk(20,21,22,23),   2, 0, 0, 1, pk(-1,-2,-3,-4));
        rstep("r_ra",   0, 0, 1, '0,                1, 0, 1, 1, pk(10,11,12,13));
        rstep("r_rb",   0, 0, 1, '0,                0, 1, 1, 1, pk(20,21,22,23));
        rstep("r_end",  0, 0, 0, '0,                0, 1, 0, 1, pk(20,21,22,23));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_layer_bridge_fifo

`default_nettype wire
